// File: rtl/adc_decim_capture.sv
// Multi-channel ADC capture with power-of-two boxcar decimation and a one-deep valid/ready output register.
// Optional ADC_DECIM_DROP_COUNT_EN adds a saturating count of results dropped under backpressure.
module adc_decim_capture #(
  parameter  int NUM_CH         = 2,
  parameter  int DATA_SIZE      = 16,
  parameter  int MAX_LOG2_DECIM = 4,
  localparam int LW             = $clog2(MAX_LOG2_DECIM + 1)
) (
  input  logic                        i_sys_clock,
  input  logic                        i_reset,
  input  logic                        i_init_done,
  input  logic                        i_enable,
  input  logic [LW-1:0]               i_log2_decim,
  input  logic                        i_sample_valid,
  input  logic [NUM_CH*DATA_SIZE-1:0] i_samples,
  output logic [NUM_CH*DATA_SIZE-1:0] o_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_overrun,
  output logic                        o_busy
`ifdef ADC_DECIM_DROP_COUNT_EN
  , output logic [15:0]               o_drop_count
`endif
);

  localparam int ACC_W = DATA_SIZE + MAX_LOG2_DECIM;
  localparam int CW    = MAX_LOG2_DECIM + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN} state_t;

  state_t                             state_q, state_d;
  logic [LW-1:0]                      k_q, k_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [NUM_CH-1:0][ACC_W-1:0]       acc_q, acc_d;
  logic [NUM_CH*DATA_SIZE-1:0]        data_q, data_d;
  logic                               valid_q, valid_d;
  logic                               overrun_q, overrun_d;

  logic                               start, leave, take, complete;
  logic                               xfer, load, drop;
  logic [LW-1:0]                      k_sel;
  logic [CW-1:0]                      cnt_inc;
  logic signed [ACC_W-1:0]            sum [NUM_CH];
  logic signed [ACC_W-1:0]            shr [NUM_CH];
  logic [NUM_CH*DATA_SIZE-1:0]        result;

  // State register
  always_ff @(posedge i_sys_clock or negedge i_reset) begin
    if (!i_reset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_enable && i_init_done)   state_d = ST_ACCUM;
      ST_ACCUM: if (!i_enable || !i_init_done) state_d = ST_DRAIN;
      ST_DRAIN: if (!valid_q || i_ready)       state_d = ST_IDLE;
      default:                                 state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy = (state_q != ST_IDLE);
  end

  assign start    = (state_q == ST_IDLE) && i_enable && i_init_done;
  assign leave    = (state_q == ST_ACCUM) && (!i_enable || !i_init_done);
  assign take     = (state_q == ST_ACCUM) && i_sample_valid;
  assign k_sel    = (i_log2_decim > LW'(MAX_LOG2_DECIM)) ? LW'(MAX_LOG2_DECIM) : i_log2_decim;
  assign cnt_inc  = cnt_q + CW'(1);
  assign complete = take && (cnt_inc == (CW'(1) << k_q));

  // Window sum including the current sample; shifting the signed sum gives the floor average.
  always_comb begin
    result = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      sum[n] = $signed(acc_q[n]) + ACC_W'($signed(i_samples[n*DATA_SIZE +: DATA_SIZE]));
      shr[n] = sum[n] >>> k_q;
      result[n*DATA_SIZE +: DATA_SIZE] = shr[n][DATA_SIZE-1:0];
    end
  end

  always_comb begin
    k_d   = k_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (start) begin
      k_d   = k_sel;
      cnt_d = '0;
      acc_d = '0;
    end else if (leave || complete) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (take) begin
      cnt_d = cnt_inc;
      for (int n = 0; n < NUM_CH; n++) acc_d[n] = sum[n];
    end
  end

  // A completing result loads if the register is empty or being emptied this edge, else it is lost.
  assign xfer      = valid_q && i_ready;
  assign load      = complete && (!valid_q || i_ready);
  assign drop      = complete && valid_q && !i_ready;
  assign valid_d   = load || (valid_q && !xfer);
  assign data_d    = load ? result : data_q;
  assign overrun_d = start ? 1'b0 : (overrun_q || drop);

  always_ff @(posedge i_sys_clock or negedge i_reset) begin
    if (!i_reset) begin
      k_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_overrun = overrun_q;

`ifdef ADC_DECIM_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (start)                             drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge i_sys_clock or negedge i_reset) begin
    if (!i_reset) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_adc_decim_capture.sv
// Bench for adc_decim_capture: vector table, directed corner sequences and a randomized run against a queue-based model.
module tb_adc_decim_capture;
  localparam int NUM_CH = 2;
  localparam int DW     = 16;
  localparam int MAXK   = 4;
  localparam int LW     = $clog2(MAXK + 1);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   init_done, enable, sample_valid, ready;
  logic [LW-1:0]          log2_decim;
  logic [NUM_CH*DW-1:0]   samples;
  logic [NUM_CH*DW-1:0]   data;
  logic                   valid, overrun, busy;
`ifdef ADC_DECIM_DROP_COUNT_EN
  logic [15:0]            drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_decim_capture #(.NUM_CH(NUM_CH), .DATA_SIZE(DW), .MAX_LOG2_DECIM(MAXK)) dut (
    .i_sys_clock    (clk),
    .i_reset        (rst_n),
    .i_init_done    (init_done),
    .i_enable       (enable),
    .i_log2_decim   (log2_decim),
    .i_sample_valid (sample_valid),
    .i_samples      (samples),
    .o_data         (data),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_overrun      (overrun),
`ifdef ADC_DECIM_DROP_COUNT_EN
    .o_drop_count   (drop_count),
`endif
    .o_busy         (busy)
  );

  typedef struct packed {
    logic [2:0]        k;
    logic [3:0][15:0]  s0;
    logic [3:0][15:0]  s1;
    logic [15:0]       e0;
    logic [15:0]       e1;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int k, input int a0, a1, a2, a3, input int b0, b1, b2, b3,
                              input int e0, input int e1);
    vec_t v;
    v.k  = 3'(k);
    v.s0 = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    v.s1 = {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
    v.e0 = 16'(e0);
    v.e1 = 16'(e1);
    return v;
  endfunction

  function automatic longint favg(input longint s, input longint n);
    if (s >= 0) return s / n;
    return -((-s + n - 1) / n);
  endfunction

  function automatic logic signed [63:0] ch(input int n);
    logic [15:0] w;
    w = data[n*DW +: DW];
    return $signed(w);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int a, input int b);
    sample_valid = 1'b1;
    samples      = {16'(b), 16'(a)};
  endtask

  task automatic start(input int k);
    enable       = 1'b1;
    init_done    = 1'b1;
    log2_decim   = LW'(k);
    sample_valid = 1'b0;
    tick();
  endtask

  task automatic stop();
    bit done;
    done         = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    ready        = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    chk("drain_to_idle", busy, 0);
  endtask

  // Randomized model state
  longint win0[$], win1[$];
  longint md0, md1;
  bit     mv, movr;
  int     mdrops;

  initial begin
    rst_n = 1'b0; init_done = 1'b0; enable = 1'b0; sample_valid = 1'b0;
    ready = 1'b0; log2_decim = '0; samples = '0;

    tbl[0] = mk(2, 4, 5, 6, 8, -1, -1, -1, -2, 5, -2);
    tbl[1] = mk(7, 32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768, 32767, -32768);
    tbl[2] = mk(1, 3, 4, 0, 0, -3, -4, 0, 0, 3, -4);
    tbl[3] = mk(0, -100, 0, 0, 0, 100, 0, 0, 0, -100, 100);
    tbl[4] = mk(3, 1, 2, 3, 4, -1, 0, 0, 0, 2, -1);
    tbl[5] = mk(4, -7, 9, 1, 2, -1, -1, -1, -1, 1, -1);

    repeat (3) @(negedge clk);
    chk("reset_valid", valid, 0);
    chk("reset_data", data, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Vector table: one full window per entry, consumer always ready
    for (int t = 0; t < 6; t++) begin
      int n, kk;
      bit early;
      kk = (int'(tbl[t].k) > MAXK) ? MAXK : int'(tbl[t].k);
      n  = 1 << kk;
      early = 1'b0;
      ready = 1'b1;
      start(int'(tbl[t].k));
      chk("tbl_busy", busy, 1);
      for (int i = 0; i < n; i++) begin
        drive(int'($signed(tbl[t].s0[i % 4])), int'($signed(tbl[t].s1[i % 4])));
        tick();
        if (i < n - 1 && valid) early = 1'b1;
      end
      sample_valid = 1'b0;
      chk("tbl_no_early_valid", early, 0);
      chk("tbl_valid", valid, 1);
      chk("tbl_ch0", ch(0), $signed(tbl[t].e0));
      chk("tbl_ch1", ch(1), $signed(tbl[t].e1));
      tick();
      chk("tbl_valid_after_xfer", valid, 0);
      stop();
    end

    // k=0 pass-through stream
    ready = 1'b1;
    start(0);
    drive(100, 1);  tick(); chk("k0_v1", valid, 1); chk("k0_d1", ch(0), 100);
    drive(-100, 2); tick(); chk("k0_v2", valid, 1); chk("k0_d2", ch(0), -100);
    drive(7, 3);    tick(); chk("k0_v3", valid, 1); chk("k0_d3", ch(0), 7);
    sample_valid = 1'b0;
    tick(); chk("k0_v_end", valid, 0);
    stop();

    // k=1 with consumer stalled: first result held, next two dropped
    ready = 1'b0;
    start(1);
    for (int i = 1; i <= 6; i++) begin
      drive(10 * i, -i);
      tick();
      if (i == 2) begin
        chk("ovr_first_valid", valid, 1);
        chk("ovr_first_ch0", ch(0), 15);
        chk("ovr_first_ch1", ch(1), -2);
      end
    end
    sample_valid = 1'b0;
    chk("ovr_held_ch0", ch(0), 15);
    chk("ovr_flag", overrun, 1);
`ifdef ADC_DECIM_DROP_COUNT_EN
    chk("ovr_drop_count", drop_count, 2);
`endif
    ready = 1'b1;
    tick();
    chk("ovr_xfer_valid", valid, 0);
    chk("ovr_sticky", overrun, 1);
    ready = 1'b0;
    stop();

    // k=3: overrun, partial window, then disable while a result is pending
    ready = 1'b0;
    start(3);
    for (int i = 0; i < 21; i++) begin
      drive(100, 100);
      tick();
    end
    sample_valid = 1'b0;
    chk("drn_pending", valid, 1);
    chk("drn_overrun", overrun, 1);
    enable = 1'b0;
    tick();
    chk("drn_busy", busy, 1);
    tick();
    chk("drn_busy_hold", busy, 1);
    chk("drn_valid_hold", valid, 1);
    ready = 1'b1;
    tick();
    chk("drn_idle", busy, 0);
    chk("drn_valid_gone", valid, 0);
    chk("drn_overrun_kept", overrun, 1);
    start(3);
    chk("drn_reenable_clears", overrun, 0);
    for (int i = 0; i < 8; i++) begin
      drive(8, -8);
      tick();
    end
    sample_valid = 1'b0;
    chk("drn_fresh_valid", valid, 1);
    chk("drn_fresh_ch0", ch(0), 8);
    chk("drn_fresh_ch1", ch(1), -8);
    stop();

    // Asynchronous reset with a pending result and a partial window
    ready = 1'b0;
    start(2);
    for (int i = 0; i < 10; i++) begin
      drive(50, -50);
      tick();
    end
    sample_valid = 1'b0;
    chk("ar_pre_valid", valid, 1);
    chk("ar_pre_overrun", overrun, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", valid, 0);
    chk("ar_data", data, 0);
    chk("ar_overrun", overrun, 0);
    chk("ar_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    tick(); tick(); tick();
    chk("ar_no_spurious", valid, 0);
    for (int i = 0; i < 4; i++) begin
      drive(9, -3);
      tick();
    end
    sample_valid = 1'b0;
    chk("ar_new_valid", valid, 1);
    chk("ar_new_ch0", ch(0), 9);
    chk("ar_new_ch1", ch(1), -3);
    stop();

    // Randomized: random gaps, data and backpressure against the queue model
    for (int run = 0; run < 6; run++) begin
      int k, n;
      k = $urandom_range(0, 5);
      n = 1 << ((k > MAXK) ? MAXK : k);
      ready = 1'b0;
      start(k);
      win0.delete(); win1.delete();
      mv = 1'b0; movr = 1'b0; mdrops = 0; md0 = 0; md1 = 0;
      for (int c = 0; c < 300; c++) begin
        logic [31:0] r;
        bit          v, rd, cmp;
        chk("rnd_valid", valid, mv);
        if (mv) begin
          chk("rnd_ch0", ch(0), md0);
          chk("rnd_ch1", ch(1), md1);
        end
        chk("rnd_overrun", overrun, movr);
`ifdef ADC_DECIM_DROP_COUNT_EN
        chk("rnd_drop_count", drop_count, mdrops);
`endif
        r  = $urandom;
        v  = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 2) == 0);
        sample_valid = v;
        samples      = r;
        ready        = rd;
        cmp = 1'b0;
        if (v) begin
          win0.push_back(longint'($signed(r[15:0])));
          win1.push_back(longint'($signed(r[31:16])));
          if (win0.size() == n) begin
            longint s0, s1;
            s0 = 0; s1 = 0;
            foreach (win0[i]) s0 += win0[i];
            foreach (win1[i]) s1 += win1[i];
            cmp = 1'b1;
            win0.delete(); win1.delete();
            if (!mv || rd) begin
              mv = 1'b1; md0 = favg(s0, n); md1 = favg(s1, n);
            end else begin
              movr = 1'b1; mdrops++;
            end
          end
        end
        if (!cmp && mv && rd) mv = 1'b0;
        tick();
      end
      stop();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_decim_capture.md
ADC_DECIM_CAPTURE -- requirements
Module: adc_decim_capture

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of ADC channels.
REQ-002 SHALL have parameter DATA_SIZE, default 16, signed two's-complement sample width per channel.
REQ-003 SHALL have parameter MAX_LOG2_DECIM, default 4, largest decimation exponent; LW = $clog2(MAX_LOG2_DECIM+1).
REQ-004 SHALL have ports:
- i_sys_clock  in  1  single clock; all logic rising-edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_init_done  in  1  ADC controller initialisation complete, active-high.
- i_enable  in  1  capture enable.
- i_log2_decim  in  LW  decimation exponent k; factor 2^k.
- i_sample_valid  in  1  i_samples valid this cycle.
- i_samples  in  NUM_CH*DATA_SIZE  packed samples; channel n at [n*DATA_SIZE +: DATA_SIZE].
- o_data  out  NUM_CH*DATA_SIZE  packed averaged results, same packing.
- o_valid  out  1  o_data valid.
- i_ready  in  1  consumer accepts o_data.
- o_overrun  out  1  sticky: a result was dropped.
- o_busy  out  1  state is not IDLE.

Function
REQ-005 SHALL implement states IDLE, ACCUM, DRAIN.
REQ-006 IDLE -> ACCUM when i_enable && i_init_done; SHALL register k = min(i_log2_decim, MAX_LOG2_DECIM) and clear accumulators and sample counter on that edge.
REQ-007 k SHALL stay constant during ACCUM; i_log2_decim changes take effect only on the next IDLE -> ACCUM.
REQ-008 In ACCUM, each cycle with i_sample_valid SHALL sign-extend every channel into a DATA_SIZE+MAX_LOG2_DECIM accumulator and add it; i_sample_valid ignored in IDLE and DRAIN.
REQ-009 Result per channel SHALL be accumulator (including the final sample) arithmetically shifted right by k, i.e. floor average, truncated to DATA_SIZE; cannot overflow.
REQ-010 On the valid edge bringing the count to 2^k samples, the result SHALL load o_data and o_valid SHALL be high the next cycle (latency 1 cycle from final sample); accumulators and counter restart from zero with no sample lost.
REQ-011 k = 0 SHALL pass each sample through with 1-cycle latency.
REQ-012 Handshake: transfer occurs on an edge with o_valid && i_ready; o_data SHALL hold stable while o_valid && !i_ready; o_valid falls after transfer unless a new result loads the same edge.
REQ-013 Result completing while o_valid && i_ready SHALL load (o_valid stays high, o_data updates).
REQ-014 Result completing while o_valid && !i_ready SHALL be dropped, o_data unchanged, o_overrun set.
REQ-015 o_overrun SHALL clear only on reset or on an IDLE -> ACCUM transition.
REQ-016 ACCUM -> DRAIN when i_enable or i_init_done is low; partial accumulation SHALL be discarded, a result completing that same edge SHALL still be loaded or dropped per REQ-013/014.
REQ-017 DRAIN -> IDLE when o_valid is low or transfers this edge.

Reset
REQ-018 On i_reset low, asynchronously: state IDLE, o_data 0, o_valid 0, o_overrun 0, o_busy 0, accumulators, counter, k 0.
REQ-019 Reset assertion mid-accumulation or with o_valid high SHALL discard all data; no transfer after reset release until new samples complete.

Configuration
REQ-020 With macro ADC_DECIM_DROP_COUNT_EN defined, SHALL add output o_drop_count, 16 bits, counting dropped results per REQ-014, saturating at 16'hFFFF, cleared like o_overrun.
REQ-021 Without ADC_DECIM_DROP_COUNT_EN, o_drop_count and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-022 k=2, i_ready=1, ch0 samples 4,5,6,8, ch1 -1,-1,-1,-2 consecutive -> one o_valid pulse one cycle after 4th sample, ch0=5, ch1=-2.
REQ-023 k=0, ch0 sequence 100,-100,7 with i_ready=1 -> o_data ch0 100,-100,7 each one cycle later, o_valid high 3 cycles.
REQ-024 k=1, i_ready=0, 6 samples -> first result held unchanged, second and third dropped, o_overrun=1, o_drop_count=2 (macro on); i_ready=1 one cycle -> transfer, o_valid 0.
REQ-025 k=3, i_enable dropped after 5 samples with output pending -> state DRAIN, o_busy 1, partial sum discarded, IDLE after i_ready accepts; re-enable clears o_overrun.
REQ-026 i_log2_decim=7 with MAX_LOG2_DECIM=4 -> result after 16 samples; DATA_SIZE=16 full-scale 16'h7FFF x16 -> 16'h7FFF, 16'h8000 x16 -> 16'h8000.
REQ-027 i_reset low mid-accumulation with o_valid high -> o_valid, o_data, o_overrun 0 immediately, no clock required.
